// File: rtl/zbt_arbiter.sv
// ZBT SRAM port arbiter: display reads take absolute priority with fixed 4-cycle latency,
// capture writes are buffered in a small FIFO and drained into idle bus cycles.
module zbt_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 19,
    parameter int DW    = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ntsc_we,
    input  logic [AW-1:0]              ntsc_addr,
    input  logic [DW-1:0]              ntsc_data,
    input  logic                       freeze,
    input  logic                       disp_req,
    input  logic [AW-1:0]              disp_addr,
    output logic [DW-1:0]              disp_data,
    output logic                       disp_valid,
    output logic [AW-1:0]              ram_addr,
    output logic                       ram_we,
    output logic [DW-1:0]              ram_wdata,
    output logic                       ram_drive,
    input  logic [DW-1:0]              ram_rdata,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Op type of the command presented on the bus in each of the three following cycles.
    op_t           op_s1;
    op_t           op_s2;
    op_t           op_s3;
    logic [DW-1:0] wd_s1;
    logic [DW-1:0] wd_s2;

    op_t  issue;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_req;
    logic push;
    logic drop;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        issue      = OP_IDLE;
        fifo_empty = (fifo_level == '0);
        fifo_full  = (fifo_level == LW'(DEPTH));
        if (disp_req) begin
            issue = OP_READ;
        end else if (!fifo_empty) begin
            issue = OP_WRITE;
        end
        pop      = (issue == OP_WRITE);
        push_req = ntsc_we && !freeze;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push     = push_req && (!fifo_full || pop);
        drop     = push_req && !push;
    end

    // NOTE: FIFO storage carries no reset; the pointers and level alone define valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ntsc_addr;
            fifo_data[wr_ptr] <= ntsc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            overflow <= overflow | drop;
        end
    end

    // Address phase, data-phase scheduling and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            ram_drive  <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            op_s1      <= OP_IDLE;
            op_s2      <= OP_IDLE;
            op_s3      <= OP_IDLE;
            wd_s1      <= '0;
            wd_s2      <= '0;
        end else begin
            case (issue)
                OP_READ: begin
                    ram_addr <= disp_addr;
                    ram_we   <= 1'b0;
                end
                OP_WRITE: begin
                    ram_addr <= fifo_addr[rd_ptr];
                    ram_we   <= 1'b1;
                end
                default: begin
                    ram_we <= 1'b0;
                end
            endcase

            op_s1 <= issue;
            op_s2 <= op_s1;
            op_s3 <= op_s2;

            if (pop) begin
                wd_s1 <= fifo_data[rd_ptr];
            end
            wd_s2 <= wd_s1;

            // The write data phase lands two cycles after its address phase.
            ram_drive <= (op_s2 == OP_WRITE);
            if (op_s2 == OP_WRITE) begin
                ram_wdata <= wd_s2;
            end

            disp_valid <= (op_s3 == OP_READ);
            if (op_s3 == OP_READ) begin
                disp_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_zbt_arbiter.sv
// Directed self-checking bench for zbt_arbiter with a 2-cycle pipelined ZBT read model
// and a delay-line scoreboard of issued display reads.
module tb_zbt_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 19;
    localparam int DW    = 36;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ntsc_we;
    logic [AW-1:0] ntsc_addr;
    logic [DW-1:0] ntsc_data;
    logic          freeze;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic          ram_drive;
    logic [DW-1:0] ram_rdata;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    always #5 clk = ~clk;

    zbt_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ntsc_we    (ntsc_we),
        .ntsc_addr  (ntsc_addr),
        .ntsc_data  (ntsc_data),
        .freeze     (freeze),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_drive  (ram_drive),
        .ram_rdata  (ram_rdata),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        if (a == 19'h00123) return 36'hA5A5A5A5A;
        return {a[17:0], ~a[17:0]};
    endfunction

    // ZBT returns data for an address two cycles after it was presented; the bus
    // carries the controller's write data whenever it drives.
    logic [AW-1:0] a_d1;
    logic [AW-1:0] a_d2;
    always @(posedge clk) begin
        a_d1 <= ram_addr;
        a_d2 <= a_d1;
    end
    assign ram_rdata = ram_drive ? ram_wdata : ram_word(a_d2);

    int            total = 0;
    int            bad   = 0;
    logic          pipe_req  [4];
    logic [AW-1:0] pipe_addr [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then check read returns against reads issued four cycles ago.
    task automatic step();
        logic          r;
        logic [AW-1:0] a;
        logic          cancel;
        r      = disp_req && !rst;
        a      = disp_addr;
        cancel = rst;
        @(posedge clk);
        #1;
        for (int k = 3; k > 0; k--) begin
            pipe_req[k]  = pipe_req[k-1];
            pipe_addr[k] = pipe_addr[k-1];
        end
        pipe_req[0]  = r;
        pipe_addr[0] = a;
        if (cancel) begin
            for (int k = 0; k < 4; k++) pipe_req[k] = 1'b0;
        end
        check("disp_valid", 64'(disp_valid), 64'(pipe_req[3]));
        if (pipe_req[3]) check("disp_data", 64'(disp_data), 64'(ram_word(pipe_addr[3])));
        if (pipe_req[2]) check("drive_on_read", 64'(ram_drive), 64'd0);
    endtask

    task automatic check_reset_values();
        check("rst_disp_data",  64'(disp_data),  64'd0);
        check("rst_disp_valid", 64'(disp_valid), 64'd0);
        check("rst_ram_addr",   64'(ram_addr),   64'd0);
        check("rst_ram_we",     64'(ram_we),     64'd0);
        check("rst_ram_wdata",  64'(ram_wdata),  64'd0);
        check("rst_ram_drive",  64'(ram_drive),  64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_overflow",   64'(overflow),   64'd0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            pipe_req[k]  = 1'b0;
            pipe_addr[k] = '0;
        end
        rst       = 1'b1;
        ntsc_we   = 1'b0;
        ntsc_addr = '0;
        ntsc_data = '0;
        freeze    = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        step();
        step();
        check_reset_values();
        rst = 1'b0;
        repeat (3) step();

        // Single display read, 4-cycle latency.
        disp_req  = 1'b1;
        disp_addr = 19'h00123;
        step();
        check("rd_addr", 64'(ram_addr), 64'h00123);
        check("rd_we",   64'(ram_we),   64'd0);
        disp_req = 1'b0;
        repeat (3) step();
        check("rd_valid_n4", 64'(disp_valid), 64'd1);
        check("rd_data_n4",  64'(disp_data),  64'hA5A5A5A5A);
        step();
        check("rd_valid_n5", 64'(disp_valid), 64'd0);

        // Single capture write, minimum latency.
        ntsc_we   = 1'b1;
        ntsc_addr = 19'h00040;
        ntsc_data = 36'h0DEADBEEF;
        step();
        check("wr_level_n1", 64'(fifo_level), 64'd1);
        check("wr_we_n1",    64'(ram_we),     64'd0);
        ntsc_we = 1'b0;
        step();
        check("wr_we_n2",    64'(ram_we),     64'd1);
        check("wr_addr_n2",  64'(ram_addr),   64'h00040);
        check("wr_level_n2", 64'(fifo_level), 64'd0);
        step();
        check("wr_we_n3",    64'(ram_we),     64'd0);
        check("wr_drive_n3", 64'(ram_drive),  64'd0);
        step();
        check("wr_drive_n4", 64'(ram_drive),  64'd1);
        check("wr_wdata_n4", 64'(ram_wdata),  64'h0DEADBEEF);
        step();
        check("wr_drive_n5", 64'(ram_drive),  64'd0);

        // Frozen writes are discarded without flagging overflow.
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ntsc_we   = 1'b1;
            ntsc_addr = AW'(32'h00080 + i);
            ntsc_data = DW'(64'h77 + i);
            step();
            check("frz_level", 64'(fifo_level), 64'd0);
            check("frz_ovf",   64'(overflow),   64'd0);
            ntsc_we = 1'b0;
            step();
            check("frz_we",    64'(ram_we),     64'd0);
        end
        freeze = 1'b0;
        repeat (3) step();
        check("frz_drive", 64'(ram_drive), 64'd0);

        // Sustained reads starve writes: 4 buffered, 2 dropped.
        for (int i = 0; i < 10; i++) begin
            disp_req  = 1'b1;
            disp_addr = AW'(32'h00200 + i);
            ntsc_we   = (i < 6);
            ntsc_addr = AW'(32'h00100 + i);
            ntsc_data = DW'(64'h1000 + i);
            step();
            check("stv_level", 64'(fifo_level), (i < 4) ? 64'(i + 1) : 64'd4);
            check("stv_ovf",   64'(overflow),   (i >= 4) ? 64'd1 : 64'd0);
            check("stv_we",    64'(ram_we),     64'd0);
        end
        disp_req = 1'b0;
        ntsc_we  = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            check("drn_we",    64'(ram_we),     64'd1);
            check("drn_addr",  64'(ram_addr),   64'(32'h00100 + j));
            check("drn_level", 64'(fifo_level), 64'(3 - j));
            if (j >= 2) begin
                check("drn_drive", 64'(ram_drive), 64'd1);
                check("drn_wdata", 64'(ram_wdata), 64'h1000 + 64'(j - 2));
            end
        end
        step();
        check("drn_we_end", 64'(ram_we),    64'd0);
        check("drn_drive4", 64'(ram_drive), 64'd1);
        check("drn_wdata4", 64'(ram_wdata), 64'h1002);
        step();
        check("drn_drive5", 64'(ram_drive), 64'd1);
        check("drn_wdata5", 64'(ram_wdata), 64'h1003);
        step();
        check("drn_drive6", 64'(ram_drive), 64'd0);
        check("drn_ovf",    64'(overflow),  64'd1);

        // Alternating reads and writes every cycle.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                disp_req  = 1'b1;
                disp_addr = AW'(32'h00300 + i);
                ntsc_we   = 1'b0;
            end else begin
                disp_req  = 1'b0;
                ntsc_we   = 1'b1;
                ntsc_addr = AW'(32'h00400 + i);
                ntsc_data = DW'(64'h5000 + i);
            end
            step();
        end
        disp_req = 1'b0;
        ntsc_we  = 1'b0;
        repeat (6) step();
        check("alt_level", 64'(fifo_level), 64'd0);
        check("alt_drive", 64'(ram_drive),  64'd0);

        // Reset mid-operation cancels in-flight write and read.
        ntsc_we   = 1'b1;
        ntsc_addr = 19'h00700;
        ntsc_data = 36'h777;
        step();
        ntsc_addr = 19'h00701;
        ntsc_data = 36'h778;
        step();
        check("mr_we",   64'(ram_we),   64'd1);
        check("mr_addr", 64'(ram_addr), 64'h00700);
        ntsc_we   = 1'b0;
        disp_req  = 1'b1;
        disp_addr = 19'h00123;
        step();
        check("mr_rd_addr", 64'(ram_addr), 64'h00123);
        rst      = 1'b1;
        ntsc_we  = 1'b1;
        step();
        check_reset_values();
        rst      = 1'b0;
        disp_req = 1'b0;
        ntsc_we  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_drive", 64'(ram_drive),  64'd0);
            check("post_we",    64'(ram_we),     64'd0);
            check("post_level", 64'(fifo_level), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
